// File: rtl/ahb_s2m_mux_s2.sv
// AHB slave-to-master response mux for two slaves plus a built-in default slave.
// The default slave answers unmapped NONSEQ/SEQ transfers with the two-cycle ERROR response.
module ahb_s2m_mux_s2 #(
    parameter int unsigned     P_DW         = 32,
    parameter logic [P_DW-1:0] P_DFLT_RDATA = '0
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            HSELd,
    input  logic            HSEL0,
    input  logic            HSEL1,
    input  logic [1:0]      HTRANS,
    input  logic [P_DW-1:0] HRDATA_S0,
    input  logic [P_DW-1:0] HRDATA_S1,
    input  logic            HREADYOUT_S0,
    input  logic            HREADYOUT_S1,
    input  logic            HRESP_S0,
    input  logic            HRESP_S1,
    output logic            HREADY,
    output logic            HRESP,
    output logic [P_DW-1:0] HRDATA
);

    localparam logic [1:0] DIDLE = 2'd0;
    localparam logic [1:0] DERR1 = 2'd1;
    localparam logic [1:0] DERR2 = 2'd2;

    localparam int DSEL_S0 = 0;
    localparam int DSEL_S1 = 1;
    localparam int DSEL_D  = 2;

    logic [2:0] dsel_reg;
    logic [2:0] dsel_next;
    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic       err_start;

    // One-hot data-phase owner; all-zero means no slave owns the data phase.
    always_comb begin
        dsel_next = 3'b000;
        if (HSEL0) begin
            dsel_next[DSEL_S0] = 1'b1;
        end else if (HSEL1) begin
            dsel_next[DSEL_S1] = 1'b1;
        end else if (HSELd) begin
            dsel_next[DSEL_D] = 1'b1;
        end
    end

    // An active transfer to unmapped space is accepted into the default slave.
    assign err_start = HREADY & HSELd & ~HSEL0 & ~HSEL1
                     & ((HTRANS == 2'b10) || (HTRANS == 2'b11));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DIDLE:   if (err_start) state_next = DERR1;
            DERR1:   state_next = DERR2;
            DERR2:   state_next = err_start ? DERR1 : DIDLE;
            default: state_next = DIDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel_reg  <= 3'b000;
            state_reg <= DIDLE;
        end else begin
            if (HREADY) begin
                dsel_reg <= dsel_next;
            end
            state_reg <= state_next;
        end
    end

    // Zero-latency return path; slave errors pass straight through.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = P_DFLT_RDATA;
        if (dsel_reg[DSEL_S0]) begin
            HREADY = HREADYOUT_S0;
            HRESP  = HRESP_S0;
            HRDATA = HRDATA_S0;
        end else if (dsel_reg[DSEL_S1]) begin
            HREADY = HREADYOUT_S1;
            HRESP  = HRESP_S1;
            HRDATA = HRDATA_S1;
        end else if (dsel_reg[DSEL_D]) begin
            HREADY = (state_reg != DERR1);
            HRESP  = (state_reg != DIDLE);
        end
    end

endmodule

// File: doc/ahb_s2m_mux_s2.md
AHB_S2M_MUX_S2 -- requirements
Module: ahb_s2m_mux_s2

Interface
REQ-001 SHALL have parameter P_DW, default 32, width of all read-data buses.
REQ-002 SHALL have parameter P_DFLT_RDATA, default 0, HRDATA value driven while the default slave owns the data phase.
REQ-003 SHALL have port HCLK  input  1  bus clock; all state on rising edge.
REQ-004 SHALL have port HRESETn  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports HSELd, HSEL0, HSEL1  input  1 each  address-phase selects from the 2-slave address decoder.
REQ-006 SHALL have port HTRANS  input  2  address-phase transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-007 SHALL have ports HRDATA_S0, HRDATA_S1  input  P_DW each  slave read data.
REQ-008 SHALL have ports HREADYOUT_S0, HREADYOUT_S1  input  1 each  slave ready.
REQ-009 SHALL have ports HRESP_S0, HRESP_S1  input  1 each  slave response (0 OKAY, 1 ERROR).
REQ-010 SHALL have port HREADY  output  1  muxed ready, returned to the master and to all slaves.
REQ-011 SHALL have port HRESP  output  1  muxed response to the master.
REQ-012 SHALL have port HRDATA  output  P_DW  muxed read data to the master.

Function
REQ-013 SHALL hold a data-phase select register DSEL (one-hot: S0, S1, D, or NONE).
REQ-014 SHALL load DSEL on any HCLK edge where HREADY=1, from the address-phase selects: priority HSEL0 > HSEL1 > HSELd; none asserted -> NONE.
REQ-015 SHALL hold DSEL unchanged while HREADY=0.
REQ-016 SHALL, with DSEL=S0, drive HREADY=HREADYOUT_S0, HRESP=HRESP_S0, HRDATA=HRDATA_S0 combinationally (zero added latency); likewise for S1.
REQ-017 SHALL, with DSEL=NONE, drive HREADY=1, HRESP=0, HRDATA=P_DFLT_RDATA.
REQ-018 SHALL implement an internal default slave FSM with states DIDLE, DERR1, DERR2.
REQ-019 SHALL transition DIDLE -> DERR1 on an edge where HREADY=1, HSELd=1, no higher-priority select, and HTRANS[1]=1 (NONSEQ/SEQ).
REQ-020 SHALL stay in DIDLE when the default slave is selected with HTRANS=IDLE or BUSY (OKAY, zero wait).
REQ-021 SHALL transition DERR1 -> DERR2 unconditionally.
REQ-022 SHALL transition DERR2 -> DERR1 if the DIDLE->DERR1 condition holds that edge, else DERR2 -> DIDLE.
REQ-023 SHALL, with DSEL=D, drive HREADY=0, HRESP=1 in DERR1; HREADY=1, HRESP=1 in DERR2; HREADY=1, HRESP=0 in DIDLE; HRDATA=P_DFLT_RDATA in all three.
REQ-024 SHALL therefore produce the AHB two-cycle ERROR response: first cycle HREADY=0/HRESP=1, second cycle HREADY=1/HRESP=1.
REQ-025 SHALL forward an S0/S1 two-cycle ERROR unmodified (pass-through; no FSM involvement).
REQ-026 SHALL, when multiple HSELx are asserted (decoder fault), resolve by the REQ-014 priority and not assert any error.
REQ-027 SHALL ignore HTRANS for S0/S1 selection (the slave itself handles IDLE/BUSY).

Reset
REQ-028 SHALL, while HRESETn=0, force DSEL=NONE and FSM=DIDLE asynchronously, giving HREADY=1, HRESP=0, HRDATA=P_DFLT_RDATA.
REQ-029 SHALL abandon any in-progress wait state or ERROR sequence on reset assertion mid-transfer, with no residual state after release.
REQ-030 SHALL sample the first address phase on the first HCLK edge after HRESETn deassertion.

Verification
REQ-031 Reset: HRESETn=0 mid DERR1 -> same cycle HREADY=1, HRESP=0, HRDATA=0; after release FSM=DIDLE.
REQ-032 S0 read with 2 waits: HSEL0=1, HTRANS=10; HREADYOUT_S0 0,0,1, HRDATA_S0=32'hA5A5_0001 -> HREADY 0,0,1, HRDATA=32'hA5A5_0001 in the final cycle, HRESP=0.
REQ-033 Back-to-back S0 then S1 (pipelined): HRDATA follows S0 in the first data phase and S1 in the next, switching exactly at the HREADY=1 edge.
REQ-034 Unmapped NONSEQ: HSELd=1, HTRANS=10 -> next two cycles HREADY/HRESP = 0/1 then 1/1, HRDATA=0; then 1/0.
REQ-035 Unmapped IDLE: HSELd=1, HTRANS=00 -> HREADY=1, HRESP=0 with no wait state; then unmapped SEQ issued in DERR2 -> DERR1 follows immediately (two consecutive ERROR pairs).
REQ-036 Slave ERROR pass-through: HRESP_S1=1 with HREADYOUT_S1 0 then 1 -> HRESP=1 both cycles, HREADY 0 then 1; HSELd asserted during the S1 wait cycle is not sampled (DSEL held).
